// File: rtl/usp_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM states, step function.
// Latency: n/a (package, purely combinational helpers).
// Backpressure: none; the register accepts a command every falling edge.
package usp_pkg;

    // Per-cycle operation codes carried on the mode input.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    // Widest register the step function can serve; instances must keep WIDTH at or below this.
    localparam int USP_MAX_W = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Next register value for one step of the given mode, on a w-bit register
    // carried in the low bits of a USP_MAX_W vector. LOAD needs the parallel
    // data, so the caller handles it; here it behaves as HOLD.
    function automatic logic [USP_MAX_W-1:0] usp_step(
        input logic [USP_MAX_W-1:0] q,
        input int unsigned          w,
        input logic [2:0]           mode,
        input logic                 sin_l,
        input logic                 sin_r
    );
        logic [USP_MAX_W-1:0] lsb_one;
        logic [USP_MAX_W-1:0] msb_one;
        logic [USP_MAX_W-1:0] mask;
        logic [USP_MAX_W-1:0] r;
        lsb_one = USP_MAX_W'(1);
        msb_one = lsb_one << (w - 1);
        mask    = (w >= USP_MAX_W) ? '1 : ((lsb_one << w) - lsb_one);
        case (mode)
            MODE_SHL: r = (q << 1) | (sin_r ? lsb_one : '0);
            MODE_SHR: r = (q >> 1) | (sin_l ? msb_one : '0);
            MODE_ROL: r = (q << 1) | (((q & msb_one) != '0) ? lsb_one : '0);
            MODE_ROR: r = (q >> 1) | (q[0] ? msb_one : '0);
            MODE_CLR: r = '0;
            MODE_INV: r = ~q;
            default:  r = q;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bundle of command inputs and register outputs of the universal shift register.
// Latency: n/a (wiring only).
// Backpressure: none; busy tells the driver that per-cycle commands are ignored.
// Ports: en/mode/d/sin_l/sin_r (per-cycle ops), burst_* (burst request), q/nq/sout_*/busy/done (status).
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic             burst_dir;
    logic             burst_rot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_l, sin_r, burst_start, burst_len, burst_dir, burst_rot,
        input  q, nq, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r, burst_start, burst_len, burst_dir, burst_rot,
        output q, nq, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/usr_burst_ctl.sv
// Burst sequencer: counts N shift/rotate steps, drives busy and a one-cycle done pulse.
// Latency: start edge loads the counter, then one step per falling edge; done on the Nth step.
// Backpressure: burst requests are ignored while a burst is running.
// Ports: burst_start/len/dir/rot in; idle, step_vld, step_mode, busy, done out.
module usr_burst_ctl
    import usp_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    input  logic             burst_rot,
    output logic             idle,
    output logic             step_vld,
    output logic [2:0]       step_mode,
    output logic             busy,
    output logic             done
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (burst_start) begin
                    if (burst_len != '0) begin
                        state_d = ST_BURST;
                        busy_d  = 1'b1;
                        cnt_d   = burst_len;
                        dir_d   = burst_dir;
                        rot_d   = burst_rot;
                    end else begin
                        // Empty burst completes immediately without touching q.
                        done_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign idle      = (state_q == ST_IDLE);
    assign step_vld  = (state_q == ST_BURST);
    assign step_mode = rot_q ? (dir_q ? MODE_ROR : MODE_ROL)
                             : (dir_q ? MODE_SHR : MODE_SHL);
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear/invert plus an N-step burst engine.
// Latency: q updates on the falling edge that applies a command; nq/sout_* follow q combinationally.
// Backpressure: while busy, per-cycle commands and new burst requests are ignored.
// Ports: clk, rst_n (sync, active-low, falling edge), bus (univ_shift_reg_if slave).
module univ_shift_reg
    import usp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    univ_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] q_q, q_d;
    logic             idle;
    logic             step_vld;
    logic [2:0]       step_mode;

    usr_burst_ctl #(
        .CNT_W (CNT_W)
    ) u_burst_ctl (
        .clk         (clk),
        .rst_n       (rst_n),
        .burst_start (bus.burst_start),
        .burst_len   (bus.burst_len),
        .burst_dir   (bus.burst_dir),
        .burst_rot   (bus.burst_rot),
        .idle        (idle),
        .step_vld    (step_vld),
        .step_mode   (step_mode),
        .busy        (bus.busy),
        .done        (bus.done)
    );

    always_comb begin
        q_d = q_q;
        if (step_vld) begin
            q_d = WIDTH'(usp_step(USP_MAX_W'(q_q), WIDTH, step_mode, bus.sin_l, bus.sin_r));
        end else if (idle && bus.en && !bus.burst_start) begin
            // A burst request in the same cycle wins over the per-cycle command.
            if (bus.mode == MODE_LOAD) begin
                q_d = bus.d;
            end else begin
                q_d = WIDTH'(usp_step(USP_MAX_W'(q_q), WIDTH, bus.mode, bus.sin_l, bus.sin_r));
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.nq     = ~q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8) with directed vectors.
// Each vector pushes the expected state after the next falling edge; a monitor
// pops one entry per rising edge and compares q/nq/sout/busy/done.
module tb_univ_shift_reg;
    import usp_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the rising edge, half a period after the
    // falling edge that produced them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".q"},      bus.q,               e.q);
                chk({e.tag, ".nq"},     bus.nq,              ~e.q);
                chk({e.tag, ".sout_l"}, {7'd0, bus.sout_l},  {7'd0, e.q[7]});
                chk({e.tag, ".sout_r"}, {7'd0, bus.sout_r},  {7'd0, e.q[0]});
                chk({e.tag, ".busy"},   {7'd0, bus.busy},    {7'd0, e.busy});
                chk({e.tag, ".done"},   {7'd0, bus.done},    {7'd0, e.done});
            end
        end
    end

    // Push the expectation for the coming falling edge, then let it happen.
    task automatic step(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        exp_t e;
        e.q = eq; e.busy = eb; e.done = ed; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic op(input logic en, input logic [2:0] mode, input logic [7:0] d);
        bus.en = en; bus.mode = mode; bus.d = d;
    endtask

    task automatic burst(input logic start, input logic [3:0] len, input logic dir, input logic rot);
        bus.burst_start = start; bus.burst_len = len; bus.burst_dir = dir; bus.burst_rot = rot;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        op(1'b1, MODE_LOAD, 8'hFF);
        @(posedge clk);
        #1;

        // 1: reset dominates a pending LOAD; then load lands on the falling edge only.
        step("rst0", 8'h00, 1'b0, 1'b0);
        step("rst1", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        op(1'b1, MODE_LOAD, 8'hA5);
        step("load_a5", 8'hA5, 1'b0, 1'b0);

        // 2: per-cycle modes.
        op(1'b1, MODE_SHL, 8'h00); bus.sin_r = 1'b1;
        step("shl", 8'h4B, 1'b0, 1'b0);
        op(1'b1, MODE_SHR, 8'h00); bus.sin_l = 1'b0;
        step("shr", 8'h25, 1'b0, 1'b0);
        op(1'b1, MODE_ROL, 8'h00);
        step("rol", 8'h4A, 1'b0, 1'b0);
        op(1'b1, MODE_ROR, 8'h00);
        step("ror", 8'h25, 1'b0, 1'b0);
        op(1'b1, MODE_INV, 8'h00);
        step("inv", 8'hDA, 1'b0, 1'b0);
        op(1'b1, MODE_CLR, 8'h00);
        step("clr", 8'h00, 1'b0, 1'b0);
        op(1'b1, MODE_HOLD, 8'h77);
        step("hold", 8'h00, 1'b0, 1'b0);
        op(1'b1, MODE_LOAD, 8'h81);
        step("load_81", 8'h81, 1'b0, 1'b0);
        op(1'b0, MODE_LOAD, 8'hFF);
        step("en0_a", 8'h81, 1'b0, 1'b0);
        step("en0_b", 8'h81, 1'b0, 1'b0);

        // 3: rotate-right burst of 3 with inputs toggling underneath.
        burst(1'b1, 4'd3, 1'b1, 1'b1);
        step("b3_start", 8'h81, 1'b1, 1'b0);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        op(1'b1, MODE_LOAD, 8'h00);
        step("b3_s1", 8'hC0, 1'b1, 1'b0);
        op(1'b0, MODE_CLR, 8'h00);
        step("b3_s2", 8'h60, 1'b1, 1'b0);
        op(1'b1, MODE_INV, 8'h00);
        burst(1'b1, 4'd7, 1'b0, 1'b0);
        step("b3_s3", 8'h30, 1'b0, 1'b1);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        op(1'b0, MODE_HOLD, 8'h00);
        step("b3_after", 8'h30, 1'b0, 1'b0);

        // 4: zero-length burst, then burst beats a same-cycle LOAD.
        burst(1'b1, 4'd0, 1'b0, 1'b0);
        step("b0", 8'h30, 1'b0, 1'b1);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        step("b0_after", 8'h30, 1'b0, 1'b0);
        burst(1'b1, 4'd2, 1'b0, 1'b1);
        op(1'b1, MODE_LOAD, 8'hFF);
        step("b2_start", 8'h30, 1'b1, 1'b0);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        op(1'b0, MODE_HOLD, 8'h00);
        step("b2_s1", 8'h60, 1'b1, 1'b0);
        step("b2_s2", 8'hC0, 1'b0, 1'b1);

        // 5: left-shift burst longer than the register, then back-to-back start.
        op(1'b1, MODE_LOAD, 8'hFF);
        step("load_ff", 8'hFF, 1'b0, 1'b0);
        op(1'b0, MODE_HOLD, 8'h00);
        bus.sin_r = 1'b0;
        burst(1'b1, 4'd10, 1'b0, 1'b0);
        step("b10_start", 8'hFF, 1'b1, 1'b0);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        step("b10_s1", 8'hFE, 1'b1, 1'b0);
        step("b10_s2", 8'hFC, 1'b1, 1'b0);
        step("b10_s3", 8'hF8, 1'b1, 1'b0);
        step("b10_s4", 8'hF0, 1'b1, 1'b0);
        step("b10_s5", 8'hE0, 1'b1, 1'b0);
        step("b10_s6", 8'hC0, 1'b1, 1'b0);
        step("b10_s7", 8'h80, 1'b1, 1'b0);
        step("b10_s8", 8'h00, 1'b1, 1'b0);
        bus.sin_r = 1'b1;
        step("b10_s9", 8'h01, 1'b1, 1'b0);
        step("b10_s10", 8'h03, 1'b0, 1'b1);
        burst(1'b1, 4'd5, 1'b1, 1'b1);
        step("b5_start", 8'h03, 1'b1, 1'b0);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        step("b5_s1", 8'h81, 1'b1, 1'b0);
        step("b5_s2", 8'hC0, 1'b1, 1'b0);

        // 6: reset aborts the burst without a done pulse; next burst is normal.
        rst_n = 1'b0;
        step("abort", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("abort_after", 8'h00, 1'b0, 1'b0);
        op(1'b1, MODE_LOAD, 8'h81);
        step("reload", 8'h81, 1'b0, 1'b0);
        op(1'b0, MODE_HOLD, 8'h00);
        bus.sin_l = 1'b1;
        burst(1'b1, 4'd2, 1'b1, 1'b0);
        step("bs_start", 8'h81, 1'b1, 1'b0);
        burst(1'b0, 4'd0, 1'b0, 1'b0);
        step("bs_s1", 8'hC0, 1'b1, 1'b0);
        step("bs_s2", 8'hE0, 1'b0, 1'b1);
        step("bs_after", 8'hE0, 1'b0, 1'b0);

        // Let the monitor drain the last entry.
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
